// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

   localparam int unsigned INST_W           = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [31:0]       pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs for the decoder.
module fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]           count_q;
   logic                    push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: requests words from instruction memory, queues them for the
// decoder, and handles redirects and halt with any in-flight request drained.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst_b,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready,
   input  logic              redirect,
   input  logic [31:0]       redirect_target,
   input  logic              halt,
   output logic              fetch_idle
);

   localparam int unsigned CNT_W = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1;

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  drain_addr_q, drain_addr_d;
   logic         halt_pend_q, halt_pend_d;

   logic             push, pop, flush, near_full;
   logic [CNT_W-1:0] q_count;
   logic             q_full, q_empty;
   fetch_entry_t     push_entry, head_entry;

   always_comb begin
      push_entry.inst = imem_rdata;
      push_entry.pc   = fetch_pc_q;
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_queue (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (push_entry),
      .rdata (head_entry),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   // Halt and redirect override both queue ports; HALT keeps the queue empty.
   assign flush      = halt | redirect | (state_q == S_HALT);
   assign inst_valid = ~q_empty & (state_q != S_HALT);
   assign pop        = inst_valid & inst_ready & ~flush;
   assign near_full  = (q_count == CNT_W'(QDEPTH - 1));

   assign inst       = head_entry.inst;
   assign inst_pc    = head_entry.pc;
   assign imem_req   = (state_q == S_REQ) || (state_q == S_DRAIN);
   assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
   assign fetch_idle = (state_q == S_HALT);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      halt_pend_d  = halt_pend_q;
      push         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (halt) begin
               state_d = S_HALT;
            end else if (redirect) begin
               fetch_pc_d = word_align(redirect_target);
               state_d    = S_REQ;
            end else if (!q_full) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (halt) begin
               if (imem_ack) begin
                  state_d = S_HALT;
               end else begin
                  halt_pend_d  = 1'b1;
                  drain_addr_d = fetch_pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (redirect) begin
               fetch_pc_d = word_align(redirect_target);
               if (!imem_ack) begin
                  drain_addr_d = fetch_pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = (pop || !near_full) ? S_REQ : S_IDLE;
            end
         end
         S_DRAIN: begin
            // The old request is still on the bus; only the restart address moves.
            if (halt) begin
               halt_pend_d = 1'b1;
            end else if (redirect && !halt_pend_q) begin
               fetch_pc_d = word_align(redirect_target);
            end
            if (imem_ack) state_d = (halt || halt_pend_q) ? S_HALT : S_REQ;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         halt_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         halt_pend_q  <= halt_pend_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a zero-wait memory echoing the address.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst_b;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        halt;
   logic        fetch_idle;

   logic        auto_ack;
   logic        man_ack;
   logic [31:0] man_rdata;

   int nchk = 0;
   int nerr = 0;

   assign imem_ack   = auto_ack ? imem_req : man_ack;
   assign imem_rdata = auto_ack ? imem_addr : man_rdata;

   instruction_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .halt            (halt),
      .fetch_idle      (fetch_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_b           = 1'b0;
      auto_ack        = 1'b1;
      man_ack         = 1'b0;
      man_rdata       = 32'h0;
      inst_ready      = 1'b1;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      halt            = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_req",   {31'b0, imem_req},   32'h0);
      chk("rst_addr",  imem_addr,           32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst",  inst,                32'h0);
      chk("rst_pc",    inst_pc,             32'h0);
      chk("rst_idle",  {31'b0, fetch_idle}, 32'h0);

      // streaming fetch, one instruction per cycle
      rst_b = 1'b1;
      tick();
      chk("req_after_rst", {31'b0, imem_req}, 32'h1);
      chk("first_addr",    imem_addr,         32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stream_valid", {31'b0, inst_valid}, 32'h1);
         chk("stream_pc",    inst_pc,             32'(4 * k));
         chk("stream_inst",  inst,                32'(4 * k));
      end

      // back-pressure: queue fills with 12,16 and fetch stops
      inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_req_low", {31'b0, imem_req}, 32'h0);
         chk("bp_head_pc", inst_pc,           32'hC);
      end
      inst_ready = 1'b1;
      tick();
      chk("bp_second", inst_pc,           32'h10);
      chk("bp_req_0",  {31'b0, imem_req}, 32'h0);
      tick();
      chk("bp_empty",  {31'b0, inst_valid}, 32'h0);
      chk("bp_addr",   imem_addr,           32'h14);
      tick();
      chk("bp_resume", inst_pc, 32'h14);

      // delayed ack with redirect in the second wait cycle
      auto_ack = 1'b0;
      tick();
      chk("dly_addr_w2", imem_addr, 32'h18);
      redirect        = 1'b1;
      redirect_target = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      chk("dly_drain_addr", imem_addr,           32'h18);
      chk("dly_drain_req",  {31'b0, imem_req},   32'h1);
      chk("dly_flushed",    {31'b0, inst_valid}, 32'h0);
      tick();
      man_ack   = 1'b1;
      man_rdata = 32'hDEAD_BEEF;
      chk("dly_addr_w4", imem_addr, 32'h18);
      tick();
      man_ack = 1'b0;
      chk("dly_dropped", {31'b0, inst_valid}, 32'h0);
      chk("dly_new_addr", imem_addr,          32'h100);
      auto_ack = 1'b1;
      tick();
      chk("dly_pc",   inst_pc, 32'h100);
      chk("dly_inst", inst,    32'h100);

      // redirect coinciding with ack, unaligned target
      redirect        = 1'b1;
      redirect_target = 32'h0000_0203;
      tick();
      redirect = 1'b0;
      chk("rda_dropped", {31'b0, inst_valid}, 32'h0);
      chk("rda_addr",    imem_addr,           32'h200);
      tick();
      chk("rda_pc", inst_pc, 32'h200);

      // address wrap at the top of memory
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("wrap_top",  imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc",   inst_pc,   32'hFFFF_FFFC);

      // halt together with redirect while a request is outstanding
      auto_ack        = 1'b0;
      halt            = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h0000_0300;
      tick();
      halt     = 1'b0;
      redirect = 1'b0;
      chk("halt_drain_req",  {31'b0, imem_req},   32'h1);
      chk("halt_drain_addr", imem_addr,           32'h0);
      chk("halt_flushed",    {31'b0, inst_valid}, 32'h0);
      chk("halt_not_idle",   {31'b0, fetch_idle}, 32'h0);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("halt_idle", {31'b0, fetch_idle}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         man_ack = (k == 1);
         tick();
         chk("halt_no_req", {31'b0, imem_req},   32'h0);
         chk("halt_sticky", {31'b0, fetch_idle}, 32'h1);
         chk("halt_no_inst", {31'b0, inst_valid}, 32'h0);
      end
      man_ack = 1'b0;

      // reset out of halt, then reset in the middle of a request
      rst_b = 1'b0;
      #1;
      chk("rst2_idle", {31'b0, fetch_idle}, 32'h0);
      @(negedge clk);
      rst_b = 1'b1;
      tick();
      chk("rst2_req", {31'b0, imem_req}, 32'h1);
      rst_b = 1'b0;
      #1;
      chk("rst_mid_req",  {31'b0, imem_req}, 32'h0);
      chk("rst_mid_addr", imem_addr,         32'h0);
      @(negedge clk);
      man_ack   = 1'b1;
      man_rdata = 32'hBAD0_BAD0;
      rst_b     = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("stray_ignored", {31'b0, inst_valid}, 32'h0);
      chk("stray_req",     {31'b0, imem_req},   32'h1);
      man_ack   = 1'b1;
      man_rdata = 32'h1234_5678;
      tick();
      man_ack = 1'b0;
      chk("post_rst_inst", inst,    32'h1234_5678);
      chk("post_rst_pc",   inst_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, is the instruction-queue depth (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 inst_valid  output  1  queue head holds an instruction for the decoder.
REQ-010 inst  output  32  head instruction; the decoder's opcode=inst[31:26] and func=inst[5:0].
REQ-011 inst_pc  output  32  address of the head instruction.
REQ-012 inst_ready  input  1  decoder accepts the head this cycle.
REQ-013 redirect  input  1  taken branch/jump/jump_register from the control unit.
REQ-014 redirect_target  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-015 halt  input  1  halted (SYSCALL) from the control unit.
REQ-016 fetch_idle  output  1  high only in HALT state.

Function
REQ-017 States SHALL be IDLE, REQ, DRAIN and HALT; imem_req SHALL equal 1 exactly in REQ and DRAIN.
REQ-018 imem_addr SHALL hold the internal fetch_pc and stay stable while imem_req=1 and imem_ack=0; ack may arrive in the request's first cycle.
REQ-019 IDLE->REQ when queue count plus outstanding request is below QDEPTH; otherwise stay IDLE.
REQ-020 REQ with ack and no redirect/halt: push {imem_rdata, fetch_pc}; fetch_pc <= fetch_pc+4 (mod 2^32 wrap); next state REQ if a slot remains after the push, else IDLE.
REQ-021 Handshake: pop when inst_valid && inst_ready; push and pop in the same cycle leave count unchanged; no push is ever issued into a full queue.
REQ-022 Redirect (not halt): flush the queue so inst_valid=0 next cycle; fetch_pc <= {redirect_target[31:2],2'b00}.
REQ-023 Redirect in REQ without ack -> DRAIN; a redirect arriving with ack discards that data and -> REQ at the new target.
REQ-024 DRAIN keeps imem_req high at the old address; on ack, discard the data and -> REQ at fetch_pc. A further redirect in DRAIN only updates fetch_pc.
REQ-025 Halt has priority over redirect, push and pop: flush the queue, issue no new request, finish any outstanding request with data discarded, then -> HALT.
REQ-026 HALT is sticky until reset: imem_req=0, inst_valid=0, fetch_idle=1.
REQ-027 Latency: with zero-wait memory and inst_ready=1, inst_valid SHALL rise one cycle after ack, sustaining one instruction per cycle.

Reset
REQ-028 rst_b low SHALL asynchronously force: state IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_idle=0.
REQ-029 imem_req SHALL rise on the first clk edge after rst_b deasserts.
REQ-030 Reset mid-request SHALL abandon the request; a later stray ack is ignored unless state is REQ or DRAIN.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, INST_W=32 and the default RESET_PC.
REQ-032 The queue SHALL be sub-module fetch_queue: synchronous FIFO with push, pop, flush, count, full and empty.

Verification
REQ-033 Reset release, zero-wait memory returning addr as data, inst_ready=1 -> inst_pc 0,4,8,... on consecutive cycles, inst equal to inst_pc.
REQ-034 inst_ready=0 for 5 cycles -> exactly 2 instructions queued, imem_req low while full, no loss or duplication after inst_ready returns to 1.
REQ-035 Ack delayed 3 cycles, redirect to 0x100 in the second wait cycle -> stale data dropped, next inst_pc=0x100.
REQ-036 Redirect to 0x203 in the same cycle as ack -> data dropped, next imem_addr=0x200.
REQ-037 halt with redirect in the same cycle and one request outstanding -> ack drained, fetch_idle=1, no further imem_req.
REQ-038 fetch_pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
